// File: rtl/param_fifo_if.sv
// Bundle of the FIFO request, data and status signals between a producer/consumer
// (master) and the FIFO itself (slave).
interface param_fifo_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3
);
   // Handshake: no ready. wr_en/rd_en are sampled on every rising edge, and each
   // sampled request gets exactly one registered ack or err pulse in the next cycle.
   // clear wins over both requests and produces no pulse.
   logic                  clear;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic [ADDR_WIDTH:0]   data_count;
   logic                  full;
   logic                  empty;
   logic                  almost_full;
   logic                  almost_empty;
   logic                  wr_ack;
   logic                  wr_err;
   logic                  rd_ack;
   logic                  rd_err;
   logic [2:0]            state_dbg;

   modport master (
      output clear, wr_en, rd_en, din,
      input  dout, data_count, full, empty, almost_full, almost_empty,
             wr_ack, wr_err, rd_ack, rd_err, state_dbg
   );

   modport slave (
      input  clear, wr_en, rd_en, din,
      output dout, data_count, full, empty, almost_full, almost_empty,
             wr_ack, wr_err, rd_ack, rd_err, state_dbg
   );
endinterface

// File: rtl/param_fifo.sv
// Single-clock FIFO with power-of-two depth, registered read data, threshold flags,
// synchronous flush and per-operation ack/err pulses.
module param_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 3,
   parameter int AFULL_TH   = 6,
   parameter int AEMPTY_TH  = 2
) (
   input logic         clk,
   input logic         reset_n,
   param_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0]   CNT_FULL   = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_AFULL  = (ADDR_WIDTH + 1)'(AFULL_TH);
   localparam logic [ADDR_WIDTH:0]   CNT_AEMPTY = (ADDR_WIDTH + 1)'(AEMPTY_TH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      INIT, NO_OP, WRITE, READ, RDWR, WR_ERROR, RD_ERROR
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   head_q, head_d;
   logic [ADDR_WIDTH-1:0]   tail_q, tail_d;
   logic [ADDR_WIDTH:0]     count_q, count_d;
   logic [DATA_WIDTH-1:0]   dout_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    wr_ack_q, wr_ack_d, wr_err_q, wr_err_d;
   logic                    rd_ack_q, rd_ack_d, rd_err_q, rd_err_d;
   logic                    do_wr, do_rd;
   logic                    is_full, is_empty;

   assign is_full  = (count_q == CNT_FULL);
   assign is_empty = (count_q == '0);

   // Operation decode; a read at full frees the slot the concurrent write needs.
   always_comb begin
      state_d  = NO_OP;
      do_wr    = 1'b0;
      do_rd    = 1'b0;
      wr_err_d = 1'b0;
      rd_err_d = 1'b0;
      if (bus.clear) begin
         state_d = INIT;
      end else begin
         case ({bus.wr_en, bus.rd_en})
            2'b10: begin
               if (is_full) begin
                  state_d  = WR_ERROR;
                  wr_err_d = 1'b1;
               end else begin
                  state_d = WRITE;
                  do_wr   = 1'b1;
               end
            end
            2'b01: begin
               if (is_empty) begin
                  state_d  = RD_ERROR;
                  rd_err_d = 1'b1;
               end else begin
                  state_d = READ;
                  do_rd   = 1'b1;
               end
            end
            2'b11: begin
               if (is_empty) begin
                  state_d  = WRITE;
                  do_wr    = 1'b1;
                  rd_err_d = 1'b1;
               end else begin
                  state_d = RDWR;
                  do_wr   = 1'b1;
                  do_rd   = 1'b1;
               end
            end
            default: state_d = NO_OP;
         endcase
      end
      wr_ack_d = do_wr;
      rd_ack_d = do_rd;
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (bus.clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_rd) head_d = head_q + PTR_ONE;
         if (do_wr) tail_d = tail_q + PTR_ONE;
         if (do_wr && !do_rd) begin
            count_d = count_q + CNT_ONE;
         end else if (do_rd && !do_wr) begin
            count_d = count_q - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= INIT;
         head_q   <= '0;
         tail_q   <= '0;
         count_q  <= '0;
         dout_q   <= '0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
         count_q  <= count_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_err_q <= rd_err_d;
         if (do_rd) dout_q <= mem[head_q];
      end
   end

   // Storage is deliberately left out of reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (do_wr) mem[tail_q] <= bus.din;
   end

   assign bus.dout         = dout_q;
   assign bus.data_count   = count_q;
   assign bus.full         = is_full;
   assign bus.empty        = is_empty;
   assign bus.almost_full  = (count_q >= CNT_AFULL);
   assign bus.almost_empty = (count_q <= CNT_AEMPTY);
   assign bus.wr_ack       = wr_ack_q;
   assign bus.wr_err       = wr_err_q;
   assign bus.rd_ack       = rd_ack_q;
   assign bus.rd_err       = rd_err_q;
   assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_param_fifo.sv
// Scenario bench for param_fifo: a queue-based reference model predicts data, count,
// flags and ack/err pulses; each scenario task compares the DUT against it.
module tb_param_fifo;
   localparam int DW    = 32;
   localparam int AW    = 3;
   localparam logic [2:0] ST_INIT = 3'd0;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   param_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   param_fifo #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .AFULL_TH  (6),
      .AEMPTY_TH (2)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] exp_dout;
   logic [3:0]    m_count;
   logic [3:0]    exp_ack;
   int            n_cmp = 0;
   int            n_err = 0;

   logic [3:0] act_ack;
   logic [3:0] act_flags;
   assign act_ack   = {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err};
   assign act_flags = {bus.full, bus.empty, bus.almost_full, bus.almost_empty};

   function automatic logic [3:0] exp_flags();
      return {m_count == 4'd8, m_count == 4'd0, m_count >= 4'd6, m_count <= 4'd2};
   endfunction

   // Driver: presents one cycle of requests, updates the model, returns at edge+1.
   task automatic apply(input logic wr, input logic rd, input logic clr,
                        input logic [DW-1:0] d);
      logic racc, wacc;
      bus.wr_en = wr;
      bus.rd_en = rd;
      bus.clear = clr;
      bus.din   = d;
      exp_ack   = 4'b0000;
      if (clr) begin
         exp_q.delete();
      end else begin
         racc    = rd && (m_count != 4'd0);
         wacc    = wr && ((m_count != 4'd8) || rd);
         exp_ack = {wacc, wr && !wacc, racc, rd && !racc};
         if (racc) exp_dout = exp_q.pop_front();
         if (wacc) exp_q.push_back(d);
      end
      m_count = 4'(exp_q.size());
      @(posedge clk);
      #1;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.clear = 1'b0;
   endtask

   task automatic goto_count(input logic [3:0] target);
      while (m_count < target) apply(1'b1, 1'b0, 1'b0, $urandom);
      while (m_count > target) apply(1'b0, 1'b1, 1'b0, '0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_count  = 4'd0;
      exp_dout = '0;
      exp_ack  = 4'b0000;
   endtask

   task automatic test_reset();
      bus.clear = 1'b0;
      bus.wr_en = 1'b0;
      bus.rd_en = 1'b0;
      bus.din   = '0;
      reset_n   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (bus.data_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.data_count); end
      n_cmp++; if (act_flags !== 4'b0101) begin n_err++; $display("FAIL reset_flags: got %b want 0101", act_flags); end
      n_cmp++; if (act_ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b want 0000", act_ack); end
      n_cmp++; if (bus.dout !== '0) begin n_err++; $display("FAIL reset_dout: got %h want 0", bus.dout); end
      n_cmp++; if (bus.state_dbg !== ST_INIT) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state_dbg, ST_INIT); end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fill();
      logic [DW-1:0] d;
      for (int i = 0; i < 9; i++) begin
         d = (i < 8) ? DW'(32'h11 * (i + 1)) : DW'(32'h99);
         apply(1'b1, 1'b0, 1'b0, d);
         n_cmp++; if (bus.data_count !== m_count) begin n_err++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.data_count, m_count); end
         n_cmp++; if (act_ack !== exp_ack) begin n_err++; $display("FAIL fill_ack[%0d]: got %b want %b", i, act_ack, exp_ack); end
         n_cmp++; if (act_flags !== exp_flags()) begin n_err++; $display("FAIL fill_flags[%0d]: got %b want %b", i, act_flags, exp_flags()); end
      end
      n_cmp++; if (act_ack !== 4'b0100) begin n_err++; $display("FAIL fill_overflow_err: got %b want 0100", act_ack); end
   endtask

   task automatic test_drain();
      for (int i = 0; i < 9; i++) begin
         apply(1'b0, 1'b1, 1'b0, '0);
         n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL drain_dout[%0d]: got %h want %h", i, bus.dout, exp_dout); end
         n_cmp++; if (bus.data_count !== m_count) begin n_err++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, bus.data_count, m_count); end
         n_cmp++; if (act_ack !== exp_ack) begin n_err++; $display("FAIL drain_ack[%0d]: got %b want %b", i, act_ack, exp_ack); end
         n_cmp++; if (act_flags !== exp_flags()) begin n_err++; $display("FAIL drain_flags[%0d]: got %b want %b", i, act_flags, exp_flags()); end
      end
      n_cmp++; if (bus.dout !== DW'(32'h88)) begin n_err++; $display("FAIL drain_hold: got %h want 88", bus.dout); end
   endtask

   task automatic test_wrap();
      logic wr, rd;
      logic [DW-1:0] d;
      for (int i = 0; i < 22; i++) begin
         wr = (i < 5) || (i >= 10 && i < 16);
         rd = !wr;
         d  = (i < 5) ? DW'($urandom) : DW'(32'hA0 + (i - 10));
         apply(wr, rd, 1'b0, d);
         n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL wrap_dout[%0d]: got %h want %h", i, bus.dout, exp_dout); end
         n_cmp++; if (bus.data_count !== m_count) begin n_err++; $display("FAIL wrap_count[%0d]: got %0d want %0d", i, bus.data_count, m_count); end
         n_cmp++; if (act_ack !== exp_ack) begin n_err++; $display("FAIL wrap_ack[%0d]: got %b want %b", i, act_ack, exp_ack); end
      end
      n_cmp++; if (bus.dout !== DW'(32'hA5)) begin n_err++; $display("FAIL wrap_last: got %h want a5", bus.dout); end
   endtask

   task automatic test_simul();
      logic [3:0] targets [3];
      targets = '{4'd3, 4'd0, 4'd8};
      for (int s = 0; s < 3; s++) begin
         goto_count(targets[s]);
         apply(1'b1, 1'b1, 1'b0, DW'($urandom));
         n_cmp++; if (bus.data_count !== m_count) begin n_err++; $display("FAIL simul_count[%0d]: got %0d want %0d", s, bus.data_count, m_count); end
         n_cmp++; if (act_ack !== exp_ack) begin n_err++; $display("FAIL simul_ack[%0d]: got %b want %b", s, act_ack, exp_ack); end
         n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL simul_dout[%0d]: got %h want %h", s, bus.dout, exp_dout); end
         n_cmp++; if (act_flags !== exp_flags()) begin n_err++; $display("FAIL simul_flags[%0d]: got %b want %b", s, act_flags, exp_flags()); end
      end
   endtask

   task automatic test_clear();
      goto_count(4'd5);
      apply(1'b1, 1'b0, 1'b1, DW'(32'hDEAD));
      n_cmp++; if (bus.data_count !== 4'd0) begin n_err++; $display("FAIL clear_count: got %0d want 0", bus.data_count); end
      n_cmp++; if (act_ack !== 4'b0000) begin n_err++; $display("FAIL clear_ack: got %b want 0000", act_ack); end
      n_cmp++; if (act_flags !== 4'b0101) begin n_err++; $display("FAIL clear_flags: got %b want 0101", act_flags); end
      n_cmp++; if (bus.state_dbg !== ST_INIT) begin n_err++; $display("FAIL clear_state: got %0d want %0d", bus.state_dbg, ST_INIT); end
      n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL clear_dout_hold: got %h want %h", bus.dout, exp_dout); end
      apply(1'b1, 1'b0, 1'b0, DW'(32'h55));
      n_cmp++; if (act_ack !== 4'b1000) begin n_err++; $display("FAIL clear_next_ack: got %b want 1000", act_ack); end
      apply(1'b0, 1'b1, 1'b0, '0);
      n_cmp++; if (bus.dout !== DW'(32'h55)) begin n_err++; $display("FAIL clear_readback: got %h want 55", bus.dout); end
   endtask

   task automatic test_async_reset();
      goto_count(4'd4);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (bus.data_count !== 4'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", bus.data_count); end
      n_cmp++; if (act_flags !== 4'b0101) begin n_err++; $display("FAIL areset_flags: got %b want 0101", act_flags); end
      n_cmp++; if (act_ack !== 4'b0000) begin n_err++; $display("FAIL areset_ack: got %b want 0000", act_ack); end
      n_cmp++; if (bus.dout !== '0) begin n_err++; $display("FAIL areset_dout: got %h want 0", bus.dout); end
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         apply(i < 3, i >= 3, 1'b0, DW'($urandom));
         n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL areset_resume_dout[%0d]: got %h want %h", i, bus.dout, exp_dout); end
         n_cmp++; if (bus.data_count !== m_count) begin n_err++; $display("FAIL areset_resume_count[%0d]: got %0d want %0d", i, bus.data_count, m_count); end
      end
   endtask

   task automatic test_random();
      logic wr, rd, clr;
      for (int i = 0; i < 300; i++) begin
         wr  = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 24) == 0);
         apply(wr, rd, clr, DW'($urandom));
         n_cmp++; if (bus.dout !== exp_dout) begin n_err++; $display("FAIL rand_dout[%0d]: got %h want %h", i, bus.dout, exp_dout); end
         n_cmp++; if (bus.data_count !== m_count) begin n_err++; $display("FAIL rand_count[%0d]: got %0d want %0d", i, bus.data_count, m_count); end
         n_cmp++; if (act_ack !== exp_ack) begin n_err++; $display("FAIL rand_ack[%0d]: got %b want %b", i, act_ack, exp_ack); end
         n_cmp++; if (act_flags !== exp_flags()) begin n_err++; $display("FAIL rand_flags[%0d]: got %b want %b", i, act_flags, exp_flags()); end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simul();
      test_clear();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
